multicycle_controller: RTL
==========================

Name: multicycle_controller

Overview:
- Multi-cycle FSM controller for the RV32I core; next generation after the single-cycle combinational decoder.
- Decodes opcode/funct3/funct7 like the single-cycle decoder, and also sequences FETCH/DECODE/EXECUTE/MEM/WB.
- Handshakes with instruction and data memories that have variable latency.
- Adds a per-access memory timeout, illegal-instruction trapping, and fully defaulted outputs: no latches, SRAI decodes to SRA.

Parameters:
- ALUOP_W, 4, width of aluop.
- MEM_TIMEOUT, 16, maximum cycles to wait for imem_ready/dmem_ready before trapping (range 1..255).
- TO_W, $clog2(MEM_TIMEOUT+1), width of the timeout counter (derived, not overridable).

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous reset, active-high.
- opcode  in  7  instruction[6:0], read from the instruction register.
- funct3  in  3  instruction[14:12].
- funct7  in  7  instruction[31:25].
- imem_ready  in  1  instruction fetch data valid this cycle.
- dmem_ready  in  1  data memory access complete this cycle.
- imem_req  out  1  instruction fetch request.
- ir_en  out  1  load the instruction register.
- pc_en  out  1  update the PC (next-PC mux uses jump/br_type).
- aluop  out  ALUOP_W  ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, PASSB=10.
- sel_a  out  1  0=rs1, 1=PC.
- sel_b  out  1  0=rs2, 1=imm.
- sel_wb  out  2  00=ALU, 01=load data, 10=PC+4.
- rf_en  out  1  register file write.
- rd_en  out  1  data memory read.
- wr_en  out  1  data memory write.
- mem_mode  out  3  000=B, 001=H, 010=W, 011=BU, 100=HU.
- br_type  out  3  funct3 for B-type; 010 (never-taken code) otherwise.
- jump  out  1  JAL/JALR.
- trap  out  1  sticky halt indicator.
- trap_cause  out  2  00=none, 01=illegal instruction, 10=imem timeout, 11=dmem timeout.
- state  out  3  current FSM state, for debug.

Behaviour:
- Reset (async, immediate): state=FETCH, timeout counter=0, trap=0, trap_cause=00.
- All outputs default to 0 every cycle, except br_type which defaults to 010.
- States: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, TRAP=5.
- FETCH:
  - imem_req=1.
  - If imem_ready: ir_en=1 for that cycle, then go to DECODE.
  - Else the counter increments. When the counter reaches MEM_TIMEOUT without imem_ready: go to TRAP, cause=10.
  - The counter clears on every state change.
- DECODE (1 cycle):
  - Illegal encodings go to TRAP, cause=01: unknown opcode; R-type funct7 other than 0000000/0100000, or 0100000 with funct3 not in {000,101}; ALU-I shift with bad funct7; load funct3 in {011,110,111}; store funct3>010; branch funct3 in {010,011}; JALR funct3≠000.
  - All legal encodings go to EXECUTE.
- EXECUTE drives aluop/sel_a/sel_b for the class:
  - R-type: sel_b=0, aluop from funct3/funct7.
  - ALU-I: sel_b=1; SRAI (funct7=0100000) gives SRA.
  - Load/store: ADD, sel_b=1.
  - Branch: sel_a=1, sel_b=1, ADD, br_type=funct3, pc_en=1, then FETCH.
  - JAL: sel_a=1. JALR: sel_a=0. Both: sel_b=1, ADD, jump=1.
  - LUI: PASSB, sel_b=1. AUIPC: ADD, sel_a=1, sel_b=1.
  - Load/store go to MEM; all others except branch go to WB.
- MEM:
  - Holds the EXECUTE ALU controls.
  - Load: rd_en=1. Store: wr_en=1.
  - mem_mode from funct3: load 000→000, 001→001, 010→010, 100→011, 101→100; store funct3 directly.
  - Requests are held until dmem_ready.
  - On dmem_ready: load goes to WB; store asserts pc_en and goes to FETCH.
  - Timeout (same counter rule as FETCH) goes to TRAP, cause=11.
- WB (1 cycle):
  - rf_en=1, pc_en=1, then FETCH.
  - sel_wb: load=01, JAL/JALR=10, else 00.
  - Hold the EXECUTE controls; JAL/JALR keep jump=1.
- TRAP: absorbing state; trap=1. All enables 0 (imem_req, ir_en, pc_en, rf_en, rd_en, wr_en). Only rst exits.
- Latency with zero-wait memories:
  - ALU/LUI/AUIPC/JAL/JALR: 4 cycles.
  - Branch: 3 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
- Simultaneous events: ready arriving on the same cycle the counter hits MEM_TIMEOUT counts as success.
- Reset mid-MEM: wr_en/rd_en drop asynchronously.

Optional Feature:
- Macro: MULDIV_EN.
- Defined:
  - Adds port md_done (in, 1).
  - R-type with funct7=0000001 is legal. aluop = 11 + funct3 (MUL..REMU occupy 11..18), which requires ALUOP_W=5; an elaboration error fires if ALUOP_W<5.
  - EXECUTE holds until md_done, with no timeout, then goes to WB.
- Undefined: funct7=0000001 traps as illegal (cause 01).

Test Plan:
- ADDI x1,x0,5 (0x00500093), imem_ready and dmem_ready always 1 → states 0,1,2,4,0; aluop=0, sel_b=1; rf_en pulses in cycle 4; pc_en=1 in WB only.
- SRAI (funct3=101, funct7=0100000, opcode 0010011) → aluop=7 in EXECUTE.
- LHU (funct3=101) with dmem_ready delayed 3 cycles → rd_en high 4 cycles with mem_mode=100; then WB with sel_wb=01.
- SW with dmem_ready never asserted, MEM_TIMEOUT=16 → after 16 MEM cycles: state=5, trap=1, trap_cause=11, wr_en=0.
- BNE (funct3=001) → br_type=001, pc_en=1 in EXECUTE, returns to FETCH after 3 cycles; opcode 0x7F → TRAP, cause=01.
- Assert rst in MEM during a store → wr_en=0 immediately, state=0 after release, trap=0.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: control bus between the RV32I multi-cycle controller and its datapath/memories
// Ports carried:
//   opcode/funct3/funct7  instruction fields from the instruction register
//   imem_ready/dmem_ready memory handshakes; md_done (MULDIV_EN only) multiply/divide completion
//   imem_req, ir_en, pc_en, aluop, sel_a, sel_b, sel_wb, rf_en, rd_en, wr_en, mem_mode, br_type, jump
//   trap, trap_cause, state  status/debug
// master = controller side, slave = datapath/memory side. Macro MULDIV_EN adds md_done.
interface multicycle_controller_if #(parameter int ALUOP_W = 4);
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic imem_ready;
    logic dmem_ready;
`ifdef MULDIV_EN
    logic md_done;
`endif
    logic imem_req;
    logic ir_en;
    logic pc_en;
    logic [ALUOP_W-1:0] aluop;
    logic sel_a;
    logic sel_b;
    logic [1:0] sel_wb;
    logic rf_en;
    logic rd_en;
    logic wr_en;
    logic [2:0] mem_mode;
    logic [2:0] br_type;
    logic jump;
    logic trap;
    logic [1:0] trap_cause;
    logic [2:0] state;
    modport master (
        input opcode, funct3, funct7, imem_ready, dmem_ready,
`ifdef MULDIV_EN
        input md_done,
`endif
        output imem_req, ir_en, pc_en, aluop, sel_a, sel_b, sel_wb, rf_en, rd_en, wr_en,
        output mem_mode, br_type, jump, trap, trap_cause, state
    );
    modport slave (
        output opcode, funct3, funct7, imem_ready, dmem_ready,
`ifdef MULDIV_EN
        output md_done,
`endif
        input imem_req, ir_en, pc_en, aluop, sel_a, sel_b, sel_wb, rf_en, rd_en, wr_en,
        input mem_mode, br_type, jump, trap, trap_cause, state
    );
endinterface

// File: rtl/multicycle_controller.sv
// multicycle_controller: RV32I multi-cycle FSM controller (FETCH/DECODE/EXECUTE/MEM/WB/TRAP)
// Ports: clk, rst (async, active-high), bus (multicycle_controller_if.master: instruction fields,
//   memory ready handshakes, datapath controls, trap status, debug state).
// Optional macro MULDIV_EN: M-extension decode (aluop 11..18, needs ALUOP_W>=5), EXECUTE waits for md_done.
module multicycle_controller #(
    parameter int ALUOP_W = 4,
    parameter int MEM_TIMEOUT = 16
) (
    input logic clk,
    input logic rst,
    multicycle_controller_if.master bus
);
    localparam int TO_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011, OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;
    typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXECUTE = 3'd2, MEM = 3'd3, WB = 3'd4, TRAP = 3'd5} state_t;
    if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255) begin : g_to_chk
        $error("MEM_TIMEOUT must be in 1..255");
    end
    state_t st, nxt;
    logic [TO_W-1:0] cnt, cnt_inc;
    logic [1:0] cause, nxt_cause;
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_auipc, is_j;
    logic md, legal, alt, cnt_hit, hold;
    logic [ALUOP_W-1:0] base_op, ex_op;
    assign op = bus.opcode;
    assign f3 = bus.funct3;
    assign f7 = bus.funct7;
    assign is_r = op == OP_R;
    assign is_i = op == OP_I;
    assign is_ld = op == OP_LD;
    assign is_st = op == OP_ST;
    assign is_br = op == OP_BR;
    assign is_jal = op == OP_JAL;
    assign is_jalr = op == OP_JALR;
    assign is_lui = op == OP_LUI;
    assign is_auipc = op == OP_AUIPC;
    assign is_j = is_jal | is_jalr;
`ifdef MULDIV_EN
    if (ALUOP_W < 5) begin : g_aluop_chk
        $error("MULDIV_EN requires ALUOP_W >= 5");
    end
    assign md = is_r && f7 == 7'b0000001;
`else
    assign md = 1'b0;
`endif
    always_comb begin
        legal = 1'b0;
        case (op)
            OP_R: legal = f7 == 7'd0 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) || md;
            OP_I: legal = f3 == 3'b001 ? f7 == 7'd0 : f3 == 3'b101 ? (f7 == 7'd0 || f7 == 7'b0100000) : 1'b1;
            OP_LD: legal = f3 != 3'b011 && f3[2:1] != 2'b11;
            OP_ST: legal = f3 <= 3'b010;
            OP_BR: legal = f3[2:1] != 2'b01;
            OP_JALR: legal = f3 == 3'b000;
            OP_JAL, OP_LUI, OP_AUIPC: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end
    // funct7[5] selects SUB/SRA; for immediates only the shift form honours it (ADDI imm bits are data)
    assign alt = f7 == 7'b0100000 && (is_r || f3 == 3'b101);
    always_comb begin
        case (f3)
            3'b000: base_op = ALUOP_W'(alt ? 1 : 0);
            3'b001: base_op = ALUOP_W'(2);
            3'b010: base_op = ALUOP_W'(3);
            3'b011: base_op = ALUOP_W'(4);
            3'b100: base_op = ALUOP_W'(5);
            3'b101: base_op = ALUOP_W'(alt ? 7 : 6);
            3'b110: base_op = ALUOP_W'(8);
            default: base_op = ALUOP_W'(9);
        endcase
    end
    assign ex_op = md ? ALUOP_W'(11 + int'(f3)) : (is_r || is_i) ? base_op : is_lui ? ALUOP_W'(10) : '0;
    assign cnt_inc = cnt + 1'b1;
    assign cnt_hit = cnt_inc == TO_W'(MEM_TIMEOUT);
    // EXECUTE's ALU controls stay valid through MEM and WB
    assign hold = st == EXECUTE || st == MEM || st == WB;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st <= FETCH;
            cnt <= '0;
            cause <= 2'b00;
        end else begin
            st <= nxt;
            cnt <= (nxt != st || !(st == FETCH || st == MEM)) ? '0 : cnt_inc;
            cause <= nxt_cause;
        end
    end
    always_comb begin
        nxt = st;
        nxt_cause = cause;
        bus.imem_req = 1'b0;
        bus.ir_en = 1'b0;
        bus.pc_en = 1'b0;
        bus.aluop = hold ? ex_op : '0;
        bus.sel_a = hold && (is_br || is_jal || is_auipc);
        bus.sel_b = hold && !is_r;
        bus.sel_wb = 2'b00;
        bus.rf_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.wr_en = 1'b0;
        bus.mem_mode = 3'b000;
        bus.br_type = 3'b010;
        bus.jump = 1'b0;
        bus.trap = 1'b0;
        case (st)
            FETCH: begin
                bus.imem_req = 1'b1;
                bus.ir_en = bus.imem_ready;
                if (bus.imem_ready) nxt = DECODE;
                else if (cnt_hit) begin
                    nxt = TRAP;
                    nxt_cause = 2'b10;
                end
            end
            DECODE: begin
                nxt = legal ? EXECUTE : TRAP;
                nxt_cause = legal ? cause : 2'b01;
            end
            EXECUTE: begin
                bus.br_type = is_br ? f3 : 3'b010;
                bus.pc_en = is_br;
                bus.jump = is_j;
                nxt = is_br ? FETCH : (is_ld || is_st) ? MEM : WB;
`ifdef MULDIV_EN
                if (md && !bus.md_done) nxt = EXECUTE;
`endif
            end
            MEM: begin
                bus.rd_en = is_ld;
                bus.wr_en = is_st;
                bus.mem_mode = !is_ld ? f3 : !f3[2] ? f3 : f3[0] ? 3'b100 : 3'b011;
                if (bus.dmem_ready) begin
                    nxt = is_ld ? WB : FETCH;
                    bus.pc_en = is_st;
                end else if (cnt_hit) begin
                    nxt = TRAP;
                    nxt_cause = 2'b11;
                end
            end
            WB: begin
                bus.rf_en = 1'b1;
                bus.pc_en = 1'b1;
                bus.sel_wb = is_ld ? 2'b01 : is_j ? 2'b10 : 2'b00;
                bus.jump = is_j;
                nxt = FETCH;
            end
            TRAP: bus.trap = 1'b1;
            default: nxt = FETCH;
        endcase
    end
    assign bus.trap_cause = cause;
    assign bus.state = st;
endmodule
